// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write arbiter and
// the round-robin picker (also intended for the read-side scheduler).
//   arb_state_t : arbiter FSM states (IDLE, GRANT)
//   idx_w(n)    : width of an index into n requesters, never less than 1
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: bundle of the requester handshakes, the FIFO
// write port and the grant status of the FIFO write arbiter.
//   req_valid/req_data/req_last : requester beats (driven by requesters)
//   req_ready                   : per-requester ready (driven by arbiter)
//   fifo_full                   : FIFO full flag (driven by the FIFO)
//   fifo_write_data/increment   : FIFO push port (driven by arbiter)
//   grant_active/grant_id       : current grant status (driven by arbiter)
// Modports: master = requesters + FIFO side, slave = arbiter side.
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 4
);
    import fifo_arb_pkg::*;

    localparam int IW = idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic [DATA_WIDTH-1:0]         fifo_write_data;
    logic                          fifo_write_increment;
    logic                          grant_active;
    logic [IW-1:0]                 grant_id;

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_write_data, fifo_write_increment,
               grant_active, grant_id
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_write_data, fifo_write_increment,
               grant_active, grant_id
    );

endinterface

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: purely combinational round-robin selector.
// Scans req upward starting at index ptr, wrapping modulo NUM_REQ, and
// returns the first set bit.
//   req   : request vector
//   ptr   : scan start index (must be < NUM_REQ)
//   found : at least one request is set
//   sel   : index of the selected request (0 when none)
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW     = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               found,
    output logic [IW-1:0]      sel
);

    // Walk offsets from farthest to nearest so the nearest hit to ptr is
    // the one that survives.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                sel   = IW'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter sharing the single cdc_fifo
// write port among NUM_REQ requesters. A grant lasts one packet (ending on
// req_last), at most BURST_LEN beats, or until the owner drops valid.
//   clk   : FIFO write clock
//   rst_n : synchronous active-low reset
//   bus   : requester handshakes, FIFO write port and grant status
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 4,
    parameter int BURST_LEN  = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    fifo_write_arbiter_if.slave bus
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] MAX_BEATS = CW'(BURST_LEN);
    localparam logic [IW-1:0] TOP_IDX   = IW'(NUM_REQ - 1);

    arb_state_t    state, state_nxt;
    logic [IW-1:0] rr_ptr, rr_ptr_nxt;
    logic [IW-1:0] owner, owner_nxt;
    logic [CW-1:0] beat_cnt, beat_cnt_nxt;
    logic [IW-1:0] pick_idx;
    logic          pick_found;
    logic          owner_valid;
    logic          owner_open;
    logic          xfer;

    rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .sel   (pick_idx)
    );

    assign owner_valid = bus.req_valid[owner];
    // Gated by rst_n so a beat in flight on the reset edge is neither
    // pushed nor acknowledged to its requester.
    assign owner_open  = rst_n && (state == GRANT) && !bus.fifo_full;
    assign xfer        = owner_open && owner_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            owner    <= owner_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        owner_nxt    = owner;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    owner_nxt    = pick_idx;
                    beat_cnt_nxt = '0;
                    state_nxt    = GRANT;
                end
            end
            GRANT: begin
                if (xfer) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                end
                // fifo_full alone never releases; a dropped valid always does.
                if ((xfer && (bus.req_last[owner] || beat_cnt_nxt == MAX_BEATS))
                    || !owner_valid) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = (owner == TOP_IDX) ? '0 : owner + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.grant_active = (state == GRANT);
        bus.grant_id     = (state == GRANT) ? owner : '0;
        bus.req_ready    = '0;
        if (owner_open) begin
            bus.req_ready[owner] = 1'b1;
        end
        bus.fifo_write_increment = xfer;
        bus.fifo_write_data      = xfer ? bus.req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH]
                                        : '0;
    end

endmodule
